// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
//   start, alu_control, op_a, op_b, mthi, mtlo : issue side (master drives)
//   busy, hi, lo                                : unit state (slave drives)
interface mult_div_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  start;
  logic [3:0]            alu_control;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic                  mthi;
  logic                  mtlo;
  logic                  busy;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  modport master (
    output start, alu_control, op_a, op_b, mthi, mtlo,
    input  busy, hi, lo
  );

  modport slave (
    input  start, alu_control, op_a, op_b, mthi, mtlo,
    output busy, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    slave side of mult_div_unit_if:
//            start/alu_control/op_a/op_b/mthi/mtlo in, busy/hi/lo out
// alu_control: 1000 DIV, 1001 DIVU, 1010 MULT, 1011 MULTU; other codes ignored.
// Accept at edge E0, result written to HI/LO at E0+DATA_WIDTH+1, busy high between.
module mult_div_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned DW    = 2 * DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]     acc_q, acc_d;      // mult: {partial, multiplier}; div: {remainder, quotient}
  logic [W-1:0]      opb_q, opb_d;      // magnitude of op_b
  logic [W-1:0]      rawa_q, rawa_d;    // raw dividend, returned in HI on divide by zero
  logic              is_mult_q, is_mult_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_a_q, neg_a_d;
  logic              dz_q, dz_d;
  logic [W-1:0]      hi_q, hi_d;
  logic [W-1:0]      lo_q, lo_d;

  // Issue-side decode and operand magnitudes
  logic          md_op;
  logic          is_signed;
  logic          a_neg, b_neg;
  logic [W-1:0]  mag_a, mag_b;

  assign md_op     = (bus.alu_control[3:2] == 2'b10);
  assign is_signed = ~bus.alu_control[0];
  assign a_neg     = is_signed & bus.op_a[W-1];
  assign b_neg     = is_signed & bus.op_b[W-1];
  assign mag_a     = a_neg ? (W'(0) - bus.op_a) : bus.op_a;
  assign mag_b     = b_neg ? (W'(0) - bus.op_b) : bus.op_b;

  // One shift-add multiply step: add multiplicand on LSB, shift accumulator right
  logic [W:0]    mult_sum;
  logic [DW-1:0] mult_next;

  assign mult_sum  = {1'b0, acc_q[DW-1:W]} + (acc_q[0] ? {1'b0, opb_q} : (W+1)'(0));
  assign mult_next = {mult_sum, acc_q[W-1:1]};

  // One restoring divide step: shift next dividend bit into remainder, subtract if it fits
  logic [W:0]    div_shift;
  logic [W:0]    div_diff;
  logic          div_ge;
  logic [W-1:0]  div_rem;
  logic [DW-1:0] div_next;

  assign div_shift = acc_q[DW-1:W-1];
  assign div_diff  = div_shift - {1'b0, opb_q};
  assign div_ge    = (div_shift >= {1'b0, opb_q});
  assign div_rem   = div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
  assign div_next  = {div_rem, acc_q[W-2:0], div_ge};

  // Sign-corrected results
  logic [DW-1:0] prod_fix;
  logic [W-1:0]  quo_fix, rem_fix;

  assign prod_fix = neg_res_q ? (DW'(0) - acc_q) : acc_q;
  assign quo_fix  = neg_res_q ? (W'(0) - acc_q[W-1:0]) : acc_q[W-1:0];
  assign rem_fix  = neg_a_q ? (W'(0) - acc_q[DW-1:W]) : acc_q[DW-1:W];

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    rawa_d    = rawa_q;
    is_mult_d = is_mult_q;
    neg_res_d = neg_res_q;
    neg_a_d   = neg_a_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (md_op) begin
            // mult/div wins over a simultaneous mthi/mtlo
            state_d   = RUN;
            cnt_d     = '0;
            acc_d     = {W'(0), mag_a};
            opb_d     = mag_b;
            rawa_d    = bus.op_a;
            is_mult_d = bus.alu_control[1];
            neg_res_d = a_neg ^ b_neg;
            neg_a_d   = a_neg;
            dz_d      = (bus.op_b == W'(0));
          end else begin
            if (bus.mthi) hi_d = bus.op_a;
            if (bus.mtlo) lo_d = bus.op_a;
          end
        end
      end
      RUN: begin
        acc_d = is_mult_q ? mult_next : div_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(W - 1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        if (is_mult_q) begin
          hi_d = prod_fix[DW-1:W];
          lo_d = prod_fix[W-1:0];
        end else if (dz_q) begin
          hi_d = rawa_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d != IDLE);

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      rawa_q    <= '0;
      is_mult_q <= 1'b0;
      neg_res_q <= 1'b0;
      neg_a_q   <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      rawa_q    <= rawa_d;
      is_mult_q <= is_mult_d;
      neg_res_q <= neg_res_d;
      neg_a_q   <= neg_a_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected {hi,lo} pushed when an operation
// is issued, popped and compared when busy falls.
module tb_mult_div_unit;

  localparam logic [3:0] C_DIV   = 4'b1000;
  localparam logic [3:0] C_DIVU  = 4'b1001;
  localparam logic [3:0] C_MULT  = 4'b1010;
  localparam logic [3:0] C_MULTU = 4'b1011;

  logic clk;
  logic reset;

  mult_div_unit_if #(.DATA_WIDTH(32)) bus ();

  mult_div_unit #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference result as {hi, lo}
  function automatic logic [63:0] model(input logic [3:0] ctl, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (ctl)
      C_MULT:  model = 64'(sa * sb);
      C_MULTU: model = ua * ub;
      C_DIV: begin
        if (b == 32'h0) model = {a, 32'hFFFF_FFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          model = {sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (b == 32'h0) model = {a, 32'hFFFF_FFFF};
        else model = {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start       = 1'b0;
    bus.alu_control = 4'b0000;
    bus.op_a        = 32'h0;
    bus.op_b        = 32'h0;
    bus.mthi        = 1'b0;
    bus.mtlo        = 1'b0;
  endtask

  // Issue one mult/div, optionally with mthi/mtlo alongside and/or mthi poked while busy
  task automatic run_op(input string tag, input logic [3:0] ctl, input logic [31:0] a,
                        input logic [31:0] b, input bit with_mt, input bit poke_mthi);
    logic [63:0] old_hilo;
    logic [63:0] exp;
    int n;
    old_hilo = {bus.hi, bus.lo};
    exp_q.push_back(model(ctl, a, b));
    bus.start       = 1'b1;
    bus.alu_control = ctl;
    bus.op_a        = a;
    bus.op_b        = b;
    bus.mthi        = with_mt;
    bus.mtlo        = with_mt;
    tick();
    idle_inputs();
    check({tag, "_hold"}, {bus.hi, bus.lo}, old_hilo);
    n = 0;
    while (bus.busy && n < 40) begin
      if (poke_mthi) begin
        bus.start = 1'b1;
        bus.mthi  = 1'b1;
        bus.op_a  = 32'h5555_AAAA;
      end
      n++;
      tick();
      if (bus.busy) check({tag, "_busyhold"}, {bus.hi, bus.lo}, old_hilo);
    end
    idle_inputs();
    check({tag, "_busycyc"}, 64'(n), 64'd33);
    exp = exp_q.pop_front();
    check({tag, "_hi"}, {32'h0, bus.hi}, {32'h0, exp[63:32]});
    check({tag, "_lo"}, {32'h0, bus.lo}, {32'h0, exp[31:0]});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    check("rst_busy", {63'h0, bus.busy}, 64'h0);
    check("rst_hilo", {bus.hi, bus.lo}, 64'h0);
    reset = 1'b0;
    tick();

    run_op("mult_neg",  C_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 1'b0);
    check("mult_neg_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op("multu_max", C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("multu_max_const", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("div_neg",   C_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
    check("div_neg_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu_7_2",  C_DIVU,  32'h0000_0007, 32'h0000_0002, 1'b0, 1'b0);
    run_op("divu_z",    C_DIVU,  32'h0000_1234, 32'h0000_0000, 1'b0, 1'b0);
    check("divu_z_const", {bus.hi, bus.lo}, 64'h0000_1234_FFFF_FFFF);
    run_op("div_z_neg", C_DIV,   32'hFFFF_FF00, 32'h0000_0000, 1'b0, 1'b0);
    run_op("div_ovf",   C_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("div_ovf_const", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
    run_op("div_mixed", C_DIV,   32'h0000_0064, 32'hFFFF_FFF9, 1'b0, 1'b0);
    run_op("mult_prio", C_MULT,  32'h0001_0000, 32'hFFFF_0000, 1'b1, 1'b0);
    run_op("mthi_busy", C_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1);

    // MTLO while idle: one-cycle write, busy stays low
    bus.start = 1'b1;
    bus.mtlo  = 1'b1;
    bus.op_a  = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    check("mtlo_lo",   {32'h0, bus.lo}, 64'h0000_0000_DEAD_BEEF);
    check("mtlo_busy", {63'h0, bus.busy}, 64'h0);

    // MTHI while idle
    bus.start = 1'b1;
    bus.mthi  = 1'b1;
    bus.op_a  = 32'h0BAD_F00D;
    tick();
    idle_inputs();
    check("mthi_hi", {32'h0, bus.hi}, 64'h0000_0000_0BAD_F00D);

    // Unsupported code is ignored
    bus.start       = 1'b1;
    bus.alu_control = 4'b0010;
    bus.op_a        = 32'h1;
    bus.op_b        = 32'h1;
    tick();
    idle_inputs();
    check("bad_code_busy", {63'h0, bus.busy}, 64'h0);
    check("bad_code_hilo", {bus.hi, bus.lo}, 64'h0BAD_F00D_DEAD_BEEF);

    // Reset mid-DIVU aborts the operation
    bus.start       = 1'b1;
    bus.alu_control = C_DIVU;
    bus.op_a        = 32'h0000_FFFF;
    bus.op_b        = 32'h0000_0003;
    tick();
    idle_inputs();
    for (int i = 0; i < 9; i++) tick();
    check("pre_rst_busy", {63'h0, bus.busy}, 64'h1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", {63'h0, bus.busy}, 64'h0);
    check("mid_rst_hilo", {bus.hi, bus.lo}, 64'h0);
    tick();
    reset = 1'b0;
    tick();
    run_op("after_rst", C_MULTU, 32'h5, 32'h6, 1'b0, 1'b0);
    check("after_rst_const", {bus.hi, bus.lo}, 64'd30);

    // Random mix, back to back
    for (int i = 0; i < 10; i++) begin
      logic [3:0]  ctl;
      logic [31:0] a, b;
      ctl = 4'b1000 | 4'($urandom_range(0, 3));
      a   = $urandom;
      b   = (i % 3 == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
      run_op("rand", ctl, a, b, 1'b0, 1'b0);
    end

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
